// File: rtl/csr_rmw_ctrl_if.sv
// Bus bundle for the CSR read-modify-write sequencer: request side, storage port and write-back.
// slave is the controller's view; master is the surrounding pipeline/storage view.
interface csr_rmw_ctrl_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        funct3;
   logic [4:0]        rs1;
   logic [4:0]        rd;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  rs1_data;
   logic [ADDR_W-1:0] csr_addr;
   logic              csr_we;
   logic [WIDTH-1:0]  csr_wdata;
   logic [WIDTH-1:0]  csr_rdata;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [WIDTH-1:0]  wb_data;
   logic              illegal;

   modport slave (
      input  req_valid, funct3, rs1, rd, addr, rs1_data, csr_rdata,
      output req_ready, csr_addr, csr_we, csr_wdata, wb_valid, wb_rd, wb_data, illegal
   );

   modport master (
      output req_valid, funct3, rs1, rd, addr, rs1_data, csr_rdata,
      input  req_ready, csr_addr, csr_we, csr_wdata, wb_valid, wb_rd, wb_data, illegal
   );
endinterface

// File: rtl/csr_rmw_ctrl.sv
// Zicsr read-modify-write sequencer in front of the CSR storage block.
// One op in flight, three cycles per op; old value is returned for rd write-back.
//
//  state   | meaning
//  S_IDLE  | ready, waiting for a request
//  S_RD    | csr_addr driven, storage read in flight
//  S_WR    | old value on csr_rdata; write / write-back / illegal decoded
module csr_rmw_ctrl #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 12
) (
   input logic           clock,
   input logic           reset,
   csr_rmw_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

   state_t            state, state_nxt;
   logic [2:0]        funct3_q;
   logic [4:0]        rs1_q;
   logic [4:0]        rd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  rs1_data_q;
   logic              accept;

   assign accept = (state == S_IDLE) && bus.req_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         funct3_q   <= '0;
         rs1_q      <= '0;
         rd_q       <= '0;
         addr_q     <= '0;
         rs1_data_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            funct3_q   <= bus.funct3;
            rs1_q      <= bus.rs1;
            rd_q       <= bus.rd;
            addr_q     <= bus.addr;
            rs1_data_q <= bus.rs1_data;
         end
      end
   end

   assign bus.csr_addr = addr_q;

   logic [WIDTH-1:0] op;
   logic [WIDTH-1:0] new_val;
   logic             write_try;
   logic             is_illegal;

   always_comb begin
      state_nxt     = state;
      op            = '0;
      new_val       = '0;
      write_try     = 1'b0;
      is_illegal    = 1'b0;
      bus.req_ready = 1'b0;
      bus.csr_we    = 1'b0;
      bus.csr_wdata = '0;
      bus.wb_valid  = 1'b0;
      bus.wb_rd     = '0;
      bus.wb_data   = '0;
      bus.illegal   = 1'b0;

      op = funct3_q[2] ? {{(WIDTH-5){1'b0}}, rs1_q} : rs1_data_q;
      unique case (funct3_q[1:0])
         2'b01:   new_val = op;
         2'b10:   new_val = bus.csr_rdata | op;
         2'b11:   new_val = bus.csr_rdata & ~op;
         default: new_val = '0;
      endcase
      // RS/RC with rs1==0 (register index or uimm) is a pure read
      write_try  = (funct3_q[1:0] == 2'b01) || (rs1_q != 5'd0);
      is_illegal = (funct3_q[1:0] == 2'b00) ||
                   ((addr_q[ADDR_W-1:ADDR_W-2] == 2'b11) && write_try);

      unique case (state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nxt = S_RD;
         end
         S_RD: state_nxt = S_WR;
         S_WR: begin
            state_nxt = S_IDLE;
            // reset in this cycle abandons the op without side effects
            if (!reset) begin
               if (is_illegal) begin
                  bus.illegal = 1'b1;
               end else begin
                  bus.csr_we    = write_try;
                  bus.csr_wdata = write_try ? new_val : '0;
                  bus.wb_valid  = (rd_q != 5'd0);
                  bus.wb_rd     = (rd_q != 5'd0) ? rd_q : 5'd0;
                  bus.wb_data   = (rd_q != 5'd0) ? bus.csr_rdata : '0;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Directed bench for csr_rmw_ctrl: stimulus pushes expected WR-cycle events into a queue,
// a negedge monitor pops and compares whenever the controller shows csr_we/wb_valid/illegal.
module tb_csr_rmw_ctrl;

   logic clock = 1'b0;
   logic reset;

   csr_rmw_ctrl_if #(.WIDTH(32), .ADDR_W(12)) bus ();

   csr_rmw_ctrl #(.WIDTH(32), .ADDR_W(12)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // CSR storage model: registered read, write on the edge closing the WR cycle
   logic [31:0] mem [0:4095];
   always @(posedge clock) begin
      if (bus.csr_we) mem[bus.csr_addr] <= bus.csr_wdata;
      bus.csr_rdata <= mem[bus.csr_addr];
   end

   typedef struct packed {
      logic        we;
      logic [31:0] wdata;
      logic [11:0] waddr;
      logic        wbv;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(input logic we, input logic [31:0] wdata, input logic [11:0] waddr,
                               input logic wbv, input logic [4:0] rd, input logic [31:0] data,
                               input logic ill);
      exp_t e;
      e.we = we; e.wdata = wdata; e.waddr = waddr;
      e.wbv = wbv; e.rd = rd; e.data = data; e.ill = ill;
      return e;
   endfunction

   always @(negedge clock) begin
      if (bus.csr_we || bus.wb_valid || bus.illegal) begin
         exp_t got;
         got = mk(bus.csr_we, bus.csr_wdata, bus.csr_addr, bus.wb_valid, bus.wb_rd, bus.wb_data,
                  bus.illegal);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_event got we=%0b wdata=%h addr=%h wbv=%0b rd=%0d data=%h ill=%0b, expected none",
                     got.we, got.wdata, got.waddr, got.wbv, got.rd, got.data, got.ill);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL wr_event got we=%0b wdata=%h addr=%h wbv=%0b rd=%0d data=%h ill=%0b exp we=%0b wdata=%h addr=%h wbv=%0b rd=%0d data=%h ill=%0b",
                        got.we, got.wdata, got.waddr, got.wbv, got.rd, got.data, got.ill,
                        e.we, e.wdata, e.waddr, e.wbv, e.rd, e.data, e.ill);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive_idle();
      bus.req_valid = 1'b0;
      bus.funct3    = '0;
      bus.rs1       = '0;
      bus.rd        = '0;
      bus.addr      = '0;
      bus.rs1_data  = '0;
   endtask

   // present a request and return just after the accepting edge
   task automatic issue(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] rdi,
                        input logic [11:0] a, input logic [31:0] d);
      int n;
      bus.funct3    = f3;
      bus.rs1       = r1;
      bus.rd        = rdi;
      bus.addr      = a;
      bus.rs1_data  = d;
      bus.req_valid = 1'b1;
      n = 0;
      @(negedge clock);
      while (!bus.req_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout req_ready=0 after %0d cycles, required 1", n);
      end
      @(posedge clock);
      #1;
      drive_idle();
   endtask

   task automatic run_op(input exp_t e, input logic push, input logic [2:0] f3,
                         input logic [4:0] r1, input logic [4:0] rdi,
                         input logic [11:0] a, input logic [31:0] d);
      if (push) exp_q.push_back(e);
      issue(f3, r1, rdi, a, d);
      repeat (3) @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t none;
      none = '0;
      reset = 1'b1;
      drive_idle();
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("reset_req_ready", {31'b0, bus.req_ready}, 32'h1);
      chk("reset_csr_addr", {20'b0, bus.csr_addr}, 32'h0);
      chk("reset_pulses", {29'b0, bus.csr_we, bus.wb_valid, bus.illegal}, 32'h0);
      @(posedge clock);
      #1;

      // CSRRW rd=5
      mem[12'h340] = 32'h0000_00F0;
      run_op(mk(1, 32'h1234_5678, 12'h340, 1, 5, 32'h0000_00F0, 0), 1,
             3'b001, 5'd1, 5'd5, 12'h340, 32'h1234_5678);

      // CSRRSI uimm=0x0F then CSRRC rs1_data=0x30
      mem[12'h340] = 32'h0000_00F0;
      run_op(mk(1, 32'h0000_00FF, 12'h340, 1, 1, 32'h0000_00F0, 0), 1,
             3'b110, 5'h0F, 5'd1, 12'h340, 32'hDEAD_BEEF);
      run_op(mk(1, 32'h0000_00CF, 12'h340, 1, 2, 32'h0000_00FF, 0), 1,
             3'b011, 5'd2, 5'd2, 12'h340, 32'h0000_0030);
      chk("mem_340_after_rc", mem[12'h340], 32'h0000_00CF);

      // read-only space: pure reads legal, attempted writes illegal
      mem[12'hC00] = 32'h0000_ABCD;
      run_op(mk(0, 0, 12'hC00, 1, 4, 32'h0000_ABCD, 0), 1,
             3'b010, 5'd0, 5'd4, 12'hC00, 32'h5555_5555);
      run_op(mk(0, 0, 12'hC00, 0, 0, 0, 1), 1,
             3'b010, 5'd3, 5'd4, 12'hC00, 32'h5555_5555);
      run_op(mk(0, 0, 12'hC00, 1, 9, 32'h0000_ABCD, 0), 1,
             3'b111, 5'd0, 5'd9, 12'hC00, 32'hFFFF_FFFF);
      run_op(mk(0, 0, 12'hC00, 0, 0, 0, 1), 1,
             3'b001, 5'd0, 5'd4, 12'hC00, 32'h0000_0001);
      chk("mem_c00_untouched", mem[12'hC00], 32'h0000_ABCD);

      // funct3=100 illegal; CSRRW rd=0 writes without write-back
      run_op(mk(0, 0, 12'h340, 0, 0, 0, 1), 1,
             3'b100, 5'd1, 5'd6, 12'h340, 32'h0000_0077);
      run_op(mk(1, 32'h0000_0055, 12'h300, 0, 0, 0, 0), 1,
             3'b001, 5'd1, 5'd0, 12'h300, 32'h0000_0055);
      chk("mem_340_after_illegal", mem[12'h340], 32'h0000_00CF);
      chk("mem_300_rd0_write", mem[12'h300], 32'h0000_0055);

      // back-to-back with req_valid held: accepts every third edge
      mem[12'h341] = 32'h0;
      exp_q.push_back(mk(1, 32'h1, 12'h341, 1, 7, 32'h0, 0));
      exp_q.push_back(mk(1, 32'h1, 12'h341, 1, 7, 32'h1, 0));
      exp_q.push_back(mk(1, 32'h1, 12'h341, 1, 7, 32'h1, 0));
      bus.funct3 = 3'b010; bus.rs1 = 5'd2; bus.rd = 5'd7;
      bus.addr = 12'h341; bus.rs1_data = 32'h1; bus.req_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clock);
         chk($sformatf("held_req_ready_c%0d", c), {31'b0, bus.req_ready},
             {31'b0, (c % 3 == 0)});
         if (c == 6) begin
            @(posedge clock);
            #1 drive_idle();
         end
      end
      repeat (2) @(posedge clock);
      #1;

      // reset during RD
      mem[12'h342] = 32'h0000_1111;
      issue(3'b001, 5'd1, 5'd1, 12'h342, 32'h0000_00AA);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_in_rd_ready", {31'b0, bus.req_ready}, 32'h1);
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_rd_no_write", mem[12'h342], 32'h0000_1111);

      // reset during WR
      issue(3'b001, 5'd1, 5'd1, 12'h342, 32'h0000_00BB);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_in_wr_we_low", {31'b0, bus.csr_we}, 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_in_wr_ready", {31'b0, bus.req_ready}, 32'h1);
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_wr_no_write", mem[12'h342], 32'h0000_1111);

      // controller still works after an abandoned op
      run_op(mk(1, 32'h0000_1133, 12'h342, 1, 3, 32'h0000_1111, 0), 1,
             3'b010, 5'd4, 5'd3, 12'h342, 32'h0000_0022);

      repeat (2) @(posedge clock);
      chk("pending_expected", exp_q.size(), 32'h0);
      if (none != '0) $display("unreachable");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
